// File: rtl/word_fifo_12_pkg.sv
// Shared constants and types for the 12-bit word FIFO and its storage array.
package word_fifo_12_pkg;

    localparam int W     = 12;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    typedef logic [W-1:0]  word_t;
    typedef logic [AW:0]   count_t;
    typedef logic [AW-1:0] ptr_t;

endpackage : word_fifo_12_pkg

// File: rtl/word_fifo_12_mem.sv
// DEPTH x W storage: one clocked write port, one asynchronous read port, no reset.
module fifo_mem_12
    import word_fifo_12_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_we,
    input  ptr_t  i_waddr,
    input  word_t i_wdata,
    input  ptr_t  i_raddr,
    output word_t o_rdata
);

    word_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read keeps the head word visible without an extra cycle.
    assign o_rdata = r_mem[i_raddr];

endmodule : fifo_mem_12

// File: rtl/word_fifo_12.sv
// First-word-fall-through FIFO for 12-bit capture words with valid/ready handshake
// and sticky overflow/underflow flags.
module word_fifo_12
    import word_fifo_12_pkg::*;
(
    input  logic   i1,
    input  logic   i2,
    input  word_t  i3,
    input  logic   i4,
    input  logic   i5,
    output logic   o1,
    output word_t  o2,
    output logic   o3,
    output count_t o4,
    output logic   o5,
    output logic   o6
);

    localparam ptr_t   PTR_ONE   = ptr_t'(1);
    localparam count_t CNT_ONE   = count_t'(1);
    localparam count_t CNT_FULL  = count_t'(DEPTH);
    localparam count_t CNT_EMPTY = count_t'(0);

    ptr_t   r_wr_ptr;
    ptr_t   r_rd_ptr;
    count_t r_count;
    logic   r_ovf;
    logic   r_udf;

    logic   w_not_full;
    logic   w_not_empty;
    logic   w_push_ok;
    logic   w_pop_ok;
    word_t  w_rdata;

    // Handshake qualifiers come from registered state only, so refused
    // requests never depend on same-cycle activity on the other port.
    assign w_not_full  = (r_count != CNT_FULL);
    assign w_not_empty = (r_count != CNT_EMPTY);
    assign w_push_ok   = i4 && w_not_full;
    assign w_pop_ok    = i5 && w_not_empty;

    fifo_mem_12 u_mem (
        .i_clk   (i1),
        .i_we    (w_push_ok && !i2),
        .i_waddr (r_wr_ptr),
        .i_wdata (i3),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i1) begin
        if (i2) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (i4 && !w_not_full) begin
                r_ovf <= 1'b1;
            end
            if (i5 && !w_not_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign o1 = w_not_full;
    assign o2 = w_rdata;
    assign o3 = w_not_empty;
    assign o4 = r_count;
    assign o5 = r_ovf;
    assign o6 = r_udf;

endmodule : word_fifo_12

// File: tb/tb_word_fifo_12.sv
// Directed bench for word_fifo_12: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_word_fifo_12;

    logic        clk;
    logic        srst;
    logic [11:0] din;
    logic        push;
    logic        pop;
    logic        o1;
    logic [11:0] o2;
    logic        o3;
    logic [2:0]  o4;
    logic        o5;
    logic        o6;

    int n_checks = 0;
    int n_errors = 0;

    word_fifo_12 dut (
        .i1 (clk),
        .i2 (srst),
        .i3 (din),
        .i4 (push),
        .i5 (pop),
        .o1 (o1),
        .o2 (o2),
        .o3 (o3),
        .o4 (o4),
        .o5 (o5),
        .o6 (o6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of at most 4 words and two sticky flags.
    logic [11:0] m_q[$];
    logic        m_ovf;
    logic        m_udf;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (srst) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            automatic bit was_full  = (m_q.size() == 4);
            automatic bit was_empty = (m_q.size() == 0);
            if (push && was_full)  m_ovf = 1'b1;
            if (pop  && was_empty) m_udf = 1'b1;
            if (pop  && !was_empty) void'(m_q.pop_front());
            if (push && !was_full)  m_q.push_back(din);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_not_full",  {31'd0, o1}, {31'd0, m_q.size() != 4});
            chk("model_not_empty", {31'd0, o3}, {31'd0, m_q.size() != 0});
            chk("model_count",     {29'd0, o4}, m_q.size());
            chk("model_ovf",       {31'd0, o5}, {31'd0, m_ovf});
            chk("model_udf",       {31'd0, o6}, {31'd0, m_udf});
            if (m_q.size() != 0) begin
                chk("model_head", {20'd0, o2}, {20'd0, m_q[0]});
            end
        end
    end

    task automatic step(input logic r, input logic p, input logic q, input logic [11:0] d);
        srst = r;
        push = p;
        pop  = q;
        din  = d;
        @(posedge clk);
        #1;
        srst = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        srst = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        din  = '0;
        @(negedge clk);

        // Reset then idle.
        step(1'b1, 1'b0, 1'b0, 12'h000);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 12'h000);
            chk("idle_not_full", {31'd0, o1}, 32'd1);
            chk("idle_empty",    {31'd0, o3}, 32'd0);
            chk("idle_count",    {29'd0, o4}, 32'd0);
            chk("idle_flags",    {30'd0, o5, o6}, 32'd0);
        end

        // Fill and drain in order.
        step(1'b0, 1'b1, 1'b0, 12'h001);
        chk("first_word_latency", {20'd0, o2}, 32'h001);
        step(1'b0, 1'b1, 1'b0, 12'hFFF);
        step(1'b0, 1'b1, 1'b0, 12'h7FE);
        step(1'b0, 1'b1, 1'b0, 12'h800);
        chk("fill_count",    {29'd0, o4}, 32'd4);
        chk("fill_not_full", {31'd0, o1}, 32'd0);
        chk("drain_0", {20'd0, o2}, 32'h001);
        step(1'b0, 1'b0, 1'b1, 12'h000);
        chk("drain_1", {20'd0, o2}, 32'hFFF);
        step(1'b0, 1'b0, 1'b1, 12'h000);
        chk("drain_2", {20'd0, o2}, 32'h7FE);
        step(1'b0, 1'b0, 1'b1, 12'h000);
        chk("drain_3", {20'd0, o2}, 32'h800);
        step(1'b0, 1'b0, 1'b1, 12'h000);
        chk("drain_count", {29'd0, o4}, 32'd0);
        chk("drain_empty", {31'd0, o3}, 32'd0);

        // Simultaneous push and pop while full.
        for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 1'b0, 12'(k));
        step(1'b0, 1'b1, 1'b1, 12'hABC);
        chk("full_pp_count", {29'd0, o4}, 32'd3);
        chk("full_pp_ovf",   {31'd0, o5}, 32'd1);
        chk("full_pp_head",  {20'd0, o2}, 32'h002);
        for (int k = 2; k <= 4; k++) begin
            chk("full_pp_order", {20'd0, o2}, 32'(k));
            step(1'b0, 1'b0, 1'b1, 12'h000);
        end
        chk("full_pp_drained", {29'd0, o4}, 32'd0);
        chk("ovf_sticky",      {31'd0, o5}, 32'd1);

        // Simultaneous push and pop while empty.
        step(1'b1, 1'b0, 1'b0, 12'h000);
        step(1'b0, 1'b1, 1'b1, 12'h155);
        chk("empty_pp_valid", {31'd0, o3}, 32'd1);
        chk("empty_pp_head",  {20'd0, o2}, 32'h155);
        chk("empty_pp_count", {29'd0, o4}, 32'd1);
        chk("empty_pp_udf",   {31'd0, o6}, 32'd1);
        chk("empty_pp_ovf",   {31'd0, o5}, 32'd0);

        // Wrap-around streaming at occupancy 2 (underflow first so reset has work to do).
        step(1'b1, 1'b0, 1'b0, 12'h000);
        step(1'b0, 1'b0, 1'b1, 12'h000);
        chk("udf_on_empty", {31'd0, o6}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 12'h100);
        step(1'b0, 1'b1, 1'b0, 12'h101);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b1, 12'h102 + 12'(k));
            chk("stream_count", {29'd0, o4}, 32'd2);
            chk("stream_head",  {20'd0, o2}, 32'h101 + 32'(k));
        end

        // Reset mid-stream at occupancy 3, then resume.
        step(1'b0, 1'b1, 1'b0, 12'h200);
        chk("pre_reset_count", {29'd0, o4}, 32'd3);
        step(1'b1, 1'b1, 1'b0, 12'h2AA);
        chk("mid_reset_count", {29'd0, o4}, 32'd0);
        chk("mid_reset_empty", {31'd0, o3}, 32'd0);
        chk("mid_reset_flags", {30'd0, o5, o6}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 12'h3C3);
        chk("post_reset_head",  {20'd0, o2}, 32'h3C3);
        chk("post_reset_valid", {31'd0, o3}, 32'd1);
        chk("post_reset_count", {29'd0, o4}, 32'd1);

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_word_fifo_12

// File: doc/word_fifo_12.md
Name: word_fifo_12

Overview:
- Synchronous 12-bit word buffer directly downstream of the 12-bit capture register bank. It absorbs the bank's sign-extended 12-bit output words and hands them to the consumer with a valid/ready handshake.
- First-word-fall-through: the head word is visible on the output while valid is high.
- Sticky overflow/underflow flags record protocol violations for formal checking.

Parameters:
- W, 12, data word width.
- DEPTH, 4, number of entries; power of two, at least 2.
- AW, log2(DEPTH) = 2, pointer width; count width is AW+1.

Ports:
- i1  input  1  clock; all state updates on posedge i1.
- i2  input  1  reset; synchronous, active-high.
- i3  input  W  write data (captured register-bank word).
- i4  input  1  push request.
- i5  input  1  pop request (consumer ready).
- o1  output 1  not-full; push accepted when i4 && o1.
- o2  output W  head word; defined only when o3=1.
- o3  output 1  not-empty (valid); pop accepted when i5 && o3.
- o4  output AW+1  current occupancy, 0..DEPTH.
- o5  output 1  sticky overflow: i4=1 while o1=0.
- o6  output 1  sticky underflow: i5=1 while o3=0.

Behaviour:
- Reset: when i2=1 at posedge i1:
  - write ptr, read ptr and count go to 0.
  - o1=1, o3=0, o4=0, o5=0, o6=0.
  - o2 is don't-care; storage contents are not cleared.
- Reset wins over push/pop in the same cycle. Reset mid-stream discards all entries.
- All outputs derive from registered state only: no combinational path from i3/i4/i5 to any output.
  - o1 = (count != DEPTH).
  - o3 = (count != 0).
  - o2 = mem[rd_ptr].
- push_ok = i4 && o1; pop_ok = i5 && o3. Both are evaluated on pre-edge state.
- push_ok: mem[wr_ptr] <= i3; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- pop_ok: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count update:
  - push_ok only: +1.
  - pop_ok only: -1.
  - both: unchanged.
  - neither: unchanged.
- Latency: a word pushed at edge N appears on o2, with o3=1, after edge N (one cycle) if the FIFO was empty.
- Boundary cases:
  - Full (count=DEPTH) with i4=1 and i5=1: pop accepted, push refused because o1 was 0. Count becomes DEPTH-1 and o5 sets.
  - Empty with i4=1 and i5=1: push accepted, pop refused because o3 was 0. Count becomes 1 and o6 sets.
  - Refused push: storage and wr_ptr unchanged.
  - Refused pop: rd_ptr unchanged.
  - Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. Order is strictly preserved.
  - o5 and o6 are cleared only by reset.
- No X on o1, o3, o4, o5 or o6 after the first reset cycle.

Decomposition:
- Shared package holds:
  - constants W=12, DEPTH=4, AW=2.
  - word typedef logic [W-1:0].
  - count typedef logic [AW:0].
- One sub-module, fifo_mem_12: DEPTH x W register array.
  - One write port (we, waddr, wdata), clocked on i1.
  - One asynchronous read port (raddr -> rdata).
  - No reset.
- Top level holds pointers, count, handshake logic and sticky flags.

Test Plan:
- Reset then idle: i2=1 for 1 cycle, then i4=i5=0 for 5 cycles -> o1=1, o3=0, o4=0, o5=0, o6=0 throughout.
- Fill and drain in order: push 0x001, 0xFFF, 0x7FE, 0x800 -> o4=4, o1=0. Pop 4 times -> o2 shows 0x001, 0xFFF, 0x7FE, 0x800 in order; o4 ends at 0 and o3=0.
- Simultaneous push and pop at full: full with 0x001..0x004, then i4=1 (i3=0xABC) and i5=1 -> o4=3, o5=1, head=0x002. 0xABC never appears on o2.
- Simultaneous push and pop at empty: i3=0x155, i4=1, i5=1 -> next cycle o3=1, o2=0x155, o4=1, o6=1.
- Wrap-around streaming: hold o4=2 while doing 10 cycles of push+pop with data 0x100+k -> o2 sequence is strictly increasing with no gaps, and o4 stays 2.
- Reset mid-stream: o4=3 and i2=1 together with i4=1 -> next cycle o4=0, o3=0, o5=0, o6=0. Next push of 0x3C3 appears on o2 one cycle later.
